seq_detector_1011: RTL and testbench

- Serial pattern detector for the bit `1011`.
- Consumes the registered Q stream produced by the flip-flop library (D/JK/RS/T cells), i.e. sits directly downstream of a flip-flop stage.
- Implemented as a 4-state FSM with a registered match pulse and a saturating match counter.
- Used as the first FSM block built on top of the flip-flop primitives.

---
 rtl/seq_detector_1011_if.sv | 30 +++
 rtl/seq_detector_1011.sv | 66 ++++++
 tb/tb_seq_detector_1011.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_1011_if.sv
// Serial-bit and result bundle between the upstream flip-flop stage and the 1011 detector.
// The detector uses the slave modport; whatever feeds it and reads it back uses master.
interface seq_detector_1011_if #(
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       state_out;

    modport master (
        output din_valid,
        output din,
        output clear,
        input  match,
        input  match_count,
        input  state_out
    );

    modport slave (
        input  din_valid,
        input  din,
        input  clear,
        output match,
        output match_count,
        output state_out
    );
endinterface

// File: rtl/seq_detector_1011.sv
// Serial detector for the bit pattern 1011 with a registered match pulse and a
// saturating match counter. All outputs come straight from flops.
//
// state  | meaning
// S_IDLE | nothing useful seen
// S_1    | seen 1
// S_10   | seen 10
// S_101  | seen 101
module seq_detector_1011 #(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    seq_detector_1011_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             match_r;
    logic [CNT_W-1:0] count_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            match_r <= 1'b0;
            count_r <= '0;
        end else if (bus.clear) begin
            state   <= S_IDLE;
            match_r <= 1'b0;
            count_r <= '0;
        end else if (!bus.din_valid) begin
            match_r <= 1'b0;
        end else begin
            match_r <= 1'b0;
            case (state)
                S_IDLE: state <= bus.din ? S_1 : S_IDLE;
                S_1:    state <= bus.din ? S_1 : S_10;
                S_10:   state <= bus.din ? S_101 : S_IDLE;
                S_101: begin
                    if (bus.din) begin
                        // The completing 1 can itself start the next pattern.
                        state   <= OVERLAP ? S_1 : S_IDLE;
                        match_r <= 1'b1;
                        if (count_r != CNT_MAX)
                            count_r <= count_r + 1'b1;
                    end else begin
                        state <= S_10;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.match       = match_r;
    assign bus.match_count = count_r;
    assign bus.state_out   = state;
endmodule

// File: tb/tb_seq_detector_1011.sv
// Directed bench for seq_detector_1011: overlapping, non-overlapping and 2-bit-counter
// instances share clock and reset; each scenario task checks its own expectations.
`timescale 1ns/1ps
module tb_seq_detector_1011;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    seq_detector_1011_if #(.CNT_W(8)) if_a ();
    seq_detector_1011_if #(.CNT_W(8)) if_b ();
    seq_detector_1011_if #(.CNT_W(2)) if_c ();

    seq_detector_1011 #(.OVERLAP(1'b1), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    seq_detector_1011 #(.OVERLAP(1'b0), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    seq_detector_1011 #(.OVERLAP(1'b1), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge to the selected instance (0=a, 1=b, 2=c); the others idle.
    task automatic drive(input int which, input logic v, input logic d, input logic c);
        @(negedge clk);
        if_a.din_valid = (which == 0) ? v : 1'b0;
        if_a.din       = (which == 0) ? d : 1'b0;
        if_a.clear     = (which == 0) ? c : 1'b0;
        if_b.din_valid = (which == 1) ? v : 1'b0;
        if_b.din       = (which == 1) ? d : 1'b0;
        if_b.clear     = (which == 1) ? c : 1'b0;
        if_c.din_valid = (which == 2) ? v : 1'b0;
        if_c.din       = (which == 2) ? d : 1'b0;
        if_c.clear     = (which == 2) ? c : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_a.din_valid = 1'b0; if_a.din = 1'b0; if_a.clear = 1'b0;
        if_b.din_valid = 1'b0; if_b.din = 1'b0; if_b.clear = 1'b0;
        if_c.din_valid = 1'b0; if_c.din = 1'b0; if_c.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (if_a.state_out !== 2'd0) $display("FAIL reset_state: got %0d expected 0", if_a.state_out);
        else pass_cnt++;
        total_cnt++;
        if (if_a.match !== 1'b0) $display("FAIL reset_match: got %0b expected 0", if_a.match);
        else pass_cnt++;
        total_cnt++;
        if (if_a.match_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", if_a.match_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1011;
        logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [3:0] exp_m = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, bits[3-i], 1'b0);
            total_cnt++;
            if (if_a.state_out !== exp_st[i])
                $display("FAIL basic_state[%0d]: got %0d expected %0d", i, if_a.state_out, exp_st[i]);
            else pass_cnt++;
            total_cnt++;
            if (if_a.match !== exp_m[3-i])
                $display("FAIL basic_match[%0d]: got %0b expected %0b", i, if_a.match, exp_m[3-i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (if_a.match_count !== 8'd1) $display("FAIL basic_count: got %0d expected 1", if_a.match_count);
        else pass_cnt++;
        drive(0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (if_a.match !== 1'b0) $display("FAIL basic_pulse_end: got %0b expected 0", if_a.match);
        else pass_cnt++;
        drive(0, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (if_a.match_count !== 8'd0 || if_a.state_out !== 2'd0)
            $display("FAIL basic_clear: got count %0d state %0d expected 0 0", if_a.match_count, if_a.state_out);
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp_m_a = 7'b0001001;
        logic [6:0] exp_m_b = 7'b0001000;
        logic [1:0] exp_st_b [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, bits[6-i], 1'b0);
            total_cnt++;
            if (if_a.match !== exp_m_a[6-i])
                $display("FAIL overlap_match[%0d]: got %0b expected %0b", i, if_a.match, exp_m_a[6-i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (if_a.match_count !== 8'd2) $display("FAIL overlap_count: got %0d expected 2", if_a.match_count);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1'b1, bits[6-i], 1'b0);
            total_cnt++;
            if (if_b.match !== exp_m_b[6-i] || if_b.state_out !== exp_st_b[i])
                $display("FAIL nooverlap[%0d]: got match %0b state %0d expected %0b %0d",
                         i, if_b.match, if_b.state_out, exp_m_b[6-i], exp_st_b[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (if_b.match_count !== 8'd1) $display("FAIL nooverlap_count: got %0d expected 1", if_b.match_count);
        else pass_cnt++;
        drive(0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gap();
        drive(0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, logic'(i[0]), 1'b0);
            total_cnt++;
            if (if_a.state_out !== 2'd2 || if_a.match !== 1'b0)
                $display("FAIL gap_hold[%0d]: got state %0d match %0b expected 2 0", i, if_a.state_out, if_a.match);
            else pass_cnt++;
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.state_out !== 2'd3 || if_a.match !== 1'b0)
            $display("FAIL gap_resume: got state %0d match %0b expected 3 0", if_a.state_out, if_a.match);
        else pass_cnt++;
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.match !== 1'b1 || if_a.match_count !== 8'd1)
            $display("FAIL gap_match: got match %0b count %0d expected 1 1", if_a.match, if_a.match_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits = 16'b1011011011011011;
        logic [15:0] exp_m = 16'b0001001001001001;
        logic [1:0]  exp_cnt [16] = '{0,0,0,1, 1,1,2, 2,2,3, 3,3,3, 3,3,3};
        for (int i = 0; i < 16; i++) begin
            drive(2, 1'b1, bits[15-i], 1'b0);
            total_cnt++;
            if (if_c.match !== exp_m[15-i] || if_c.match_count !== exp_cnt[i])
                $display("FAIL sat[%0d]: got match %0b count %0d expected %0b %0d",
                         i, if_c.match, if_c.match_count, exp_m[15-i], exp_cnt[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        // dut_a enters in S_1 with a count of 1 from the gap scenario.
        drive(0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.state_out !== 2'd3) $display("FAIL arst_pre: got %0d expected 3", if_a.state_out);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if_a.state_out !== 2'd0 || if_a.match_count !== 8'd0 || if_a.match !== 1'b0)
            $display("FAIL arst_immediate: got state %0d count %0d match %0b expected 0 0 0",
                     if_a.state_out, if_a.match_count, if_a.match);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.state_out !== 2'd1 || if_a.match !== 1'b0)
            $display("FAIL arst_resume: got state %0d match %0b expected 1 0", if_a.state_out, if_a.match);
        else pass_cnt++;
    endtask

    task automatic test_clear_collision();
        logic [6:0] bits = 7'b1011011;
        drive(0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(0, 1'b1, bits[6-i], 1'b0);
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.match_count !== 8'd2 || if_a.state_out !== 2'd3)
            $display("FAIL clr_setup: got count %0d state %0d expected 2 3", if_a.match_count, if_a.state_out);
        else pass_cnt++;
        drive(0, 1'b1, 1'b1, 1'b1);
        total_cnt++;
        if (if_a.match !== 1'b0 || if_a.match_count !== 8'd0 || if_a.state_out !== 2'd0)
            $display("FAIL clr_wins: got match %0b count %0d state %0d expected 0 0 0",
                     if_a.match, if_a.match_count, if_a.state_out);
        else pass_cnt++;
        drive(0, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (if_a.state_out !== 2'd1) $display("FAIL clr_after: got %0d expected 1", if_a.state_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_gap();
        test_back_to_back();
        test_async_reset();
        test_clear_collision();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
